demux_scan_ctrl: RTL and testbench
==================================

DEMUX_SCAN_CTRL -- requirements
Module: demux_scan_ctrl

Interface
REQ-001 SHALL have parameter: DWELL_W, default 8, width of the dwell count.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port: start  input  1  begin scan; sampled only in IDLE.
REQ-005 SHALL have port: stop  input  1  abort scan; sampled in every state.
REQ-006 SHALL have port: first_ch  input  5  first channel of a pass; sampled when start is accepted.
REQ-007 SHALL have port: last_ch  input  5  final channel of a pass; sampled when start is accepted.
REQ-008 SHALL have port: dwell  input  DWELL_W  enable-high cycles per channel; sampled when start is accepted; 0 is treated as 1.
REQ-009 SHALL have port: single  input  1  1 = one pass then stop, 0 = repeat passes; sampled when start is accepted.
REQ-010 SHALL have port: ch_mask  input  32  per-channel enable, bit i = 1 drives channel i; present only with CH_MASK_EN.
REQ-011 SHALL have port: a  output  5  channel address to the 5-to-32 decoder.
REQ-012 SHALL have port: en  output  1  decoder enable, active-high.
REQ-013 SHALL have port: busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port: done  output  1  one-cycle pulse at the end of a completed single pass.

Function
REQ-015 SHALL implement states IDLE, SETUP and DRIVE.
REQ-016 SHALL register a, en, busy and done; no combinational path from any input to any output.
REQ-017 SHALL, in IDLE, on start=1 and stop=0, load a=first_ch, latch the configuration and enter SETUP.
REQ-018 SHALL hold en=0 in SETUP for exactly one cycle (address settle, break-before-make), then enter DRIVE.
REQ-019 SHALL hold en=1 and a constant in DRIVE for max(dwell,1) cycles.
REQ-020 SHALL, at DRIVE expiry with a!=last_ch, set a=(a+1) mod 32 and enter SETUP.
REQ-021 SHALL, when first_ch>last_ch, step from 31 to 0 and continue to last_ch.
REQ-022 SHALL, at DRIVE expiry with a==last_ch and single=1, enter IDLE and pulse done for one cycle.
REQ-023 SHALL, at DRIVE expiry with a==last_ch and single=0, set a=first_ch and enter SETUP.
REQ-024 SHALL treat first_ch==last_ch as a one-channel pass.
REQ-025 SHALL, on stop=1 in any state, enter IDLE next cycle with en=0, done=0 and a held.
REQ-026 SHALL give stop priority over start when both are high in the same cycle.
REQ-027 SHALL ignore start while busy=1.
REQ-028 SHALL ignore input changes during a scan; only the latched configuration is used.
REQ-029 SHALL meet this timing: start accepted at edge N gives busy=1 and a=first_ch after N+1, and en=1 after N+2 through N+1+dwell.

Reset
REQ-030 SHALL, while rst_n=0, force state=IDLE, a=0, en=0, busy=0, done=0 and dwell counter=0, regardless of clk.
REQ-031 SHALL, on reset mid-scan, abandon the scan with no done pulse and resume only on a new start.

Configuration
REQ-032 SHALL, with CH_MASK_EN defined, add port ch_mask, sampled each SETUP; a channel with mask bit 0 spends its SETUP cycle with en=0, skips DRIVE and advances per REQ-020/022/023.
REQ-033 SHALL, with CH_MASK_EN defined and all bits 0, never assert en; single passes still pulse done.
REQ-034 SHALL, without CH_MASK_EN, omit ch_mask and drive every channel in range.

Verification
REQ-035 SHALL cover: reset, then start with first=0, last=2, dwell=3, single=1 -> a=0,1,2, each preceded by 1 en=0 cycle, en high 3 cycles each; done pulses once; busy=0 after.
REQ-036 SHALL cover: first=30, last=1, dwell=1, single=1 -> a sequence 30,31,0,1; done pulses.
REQ-037 SHALL cover: dwell=0, first=last=5 -> en high exactly 1 cycle with a=5; done pulses.
REQ-038 SHALL cover: single=0, first=3, last=4; stop asserted during second pass -> en=0 next cycle; no done; start re-accepted afterwards.
REQ-039 SHALL cover: start and stop in the same cycle, and rst_n low mid-DRIVE -> both stay in or return to IDLE; a=0 after reset; outputs zero.
REQ-040 SHALL cover: with CH_MASK_EN, ch_mask=32'h0000_0005, first=0, last=3 -> en high only for a=0 and a=2.

Source files
------------

// File: rtl/demux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : demux_scan_ctrl
// Description : Scan controller for a 5-to-32 address decoder. It steps a
//               channel address from first_ch to last_ch, wrapping 31->0, and
//               holds the decoder enable high for a programmable dwell on each
//               channel. Every channel is preceded by one enable-low settle
//               cycle (break-before-make). Passes run once or repeat.
//               Optional feature macro: CH_MASK_EN adds a per-channel enable
//               mask (ch_mask) that is sampled in each SETUP cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module demux_scan_ctrl #(
    parameter int unsigned DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic [4:0]         first_ch,
    input  logic [4:0]         last_ch,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               single,
`ifdef CH_MASK_EN
    input  logic [31:0]        ch_mask,
`endif
    output logic [4:0]         a,
    output logic               en,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;

    localparam logic [DWELL_W-1:0] c_one = DWELL_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [4:0]         r_first;
    logic [4:0]         r_last;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_single;

    logic [4:0]         w_a_nxt;
    logic               w_en_nxt;
    logic               w_done_nxt;
    logic               w_load_cfg;

    logic               w_ch_on;
    logic               w_last_hit;
    logic               w_expire;
    logic [DWELL_W-1:0] w_dwell_eff;
    logic [4:0]         w_a_adv;
    logic               w_pass_end;

`ifdef CH_MASK_EN
    assign w_ch_on = ch_mask[a];
`else
    assign w_ch_on = 1'b1;
`endif

    // A zero dwell is stretched to one enabled cycle
    assign w_dwell_eff = (r_dwell == '0) ? c_one : r_dwell;
    assign w_last_hit  = (a == r_last);
    assign w_expire    = (r_cnt <= c_one);
    // End of a single pass returns to IDLE; otherwise the address advances
    assign w_pass_end  = w_last_hit && r_single;
    assign w_a_adv     = w_last_hit ? (r_single ? a : r_first) : 5'(a + 5'd1);

    // State, outputs, dwell counter and latched configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            a        <= 5'd0;
            en       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            r_cnt    <= '0;
            r_first  <= 5'd0;
            r_last   <= 5'd0;
            r_dwell  <= '0;
            r_single <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            a       <= w_a_nxt;
            en      <= w_en_nxt;
            busy    <= (w_state_nxt != S_IDLE);
            done    <= w_done_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_load_cfg) begin
                r_first  <= first_ch;
                r_last   <= last_ch;
                r_dwell  <= dwell;
                r_single <= single;
            end
        end
    end

    // Next-state selection; stop overrides every other transition
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_SETUP;
            end
            S_SETUP: begin
                if (w_ch_on)         w_state_nxt = S_DRIVE;
                else if (w_pass_end) w_state_nxt = S_IDLE;
                else                 w_state_nxt = S_SETUP;
            end
            S_DRIVE: begin
                if (w_expire) w_state_nxt = w_pass_end ? S_IDLE : S_SETUP;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (stop) w_state_nxt = S_IDLE;
    end

    // Next values for the registered outputs and the dwell counter
    always_comb begin
        w_a_nxt    = a;
        w_en_nxt   = 1'b0;
        w_done_nxt = 1'b0;
        w_cnt_nxt  = r_cnt;
        w_load_cfg = 1'b0;
        if (!stop) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        w_a_nxt    = first_ch;
                        w_load_cfg = 1'b1;
                    end
                end
                S_SETUP: begin
                    if (w_ch_on) begin
                        w_en_nxt  = 1'b1;
                        w_cnt_nxt = w_dwell_eff;
                    end else begin
                        w_a_nxt    = w_a_adv;
                        w_done_nxt = w_pass_end;
                    end
                end
                S_DRIVE: begin
                    if (!w_expire) begin
                        w_en_nxt  = 1'b1;
                        w_cnt_nxt = r_cnt - c_one;
                    end else begin
                        w_cnt_nxt  = '0;
                        w_a_nxt    = w_a_adv;
                        w_done_nxt = w_pass_end;
                    end
                end
                default: begin
                    w_cnt_nxt = '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_demux_scan_ctrl
// Description : Directed self-checking bench for demux_scan_ctrl. Build with
//               CH_MASK_EN defined to also exercise the channel mask.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [4:0] first_ch = 5'd0;
    logic [4:0] last_ch = 5'd0;
    logic [7:0] dwell = 8'd0;
    logic       single = 1'b0;
`ifdef CH_MASK_EN
    logic [31:0] ch_mask = 32'hFFFF_FFFF;
`endif
    logic [4:0] a;
    logic       en;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    demux_scan_ctrl #(.DWELL_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stop     (stop),
        .first_ch (first_ch),
        .last_ch  (last_ch),
        .dwell    (dwell),
        .single   (single),
`ifdef CH_MASK_EN
        .ch_mask  (ch_mask),
`endif
        .a        (a),
        .en       (en),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling or driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] ea, input logic een,
                       input logic ebusy, input logic edone);
        logic [7:0] got;
        logic [7:0] exp;
        got = {a, en, busy, done};
        exp = {ea, een, ebusy, edone};
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got a=%0d en=%b busy=%b done=%b exp a=%0d en=%b busy=%b done=%b",
                   tag, got[7:3], got[2], got[1], got[0], ea, een, ebusy, edone);
        end
    endtask

    initial begin
        int seq2[4];
        seq2 = '{30, 31, 0, 1};

        // Reset
        step();
        step();
        chk("reset", 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", 5'd0, 1'b0, 1'b0, 1'b0);

        // Pass 0..2, dwell 3, single; inputs disturbed mid-scan
        first_ch = 5'd0; last_ch = 5'd2; dwell = 8'd3; single = 1'b1; start = 1'b1;
        step();
        chk("t1_setup0", 5'd0, 1'b0, 1'b1, 1'b0);
        start = 1'b0; first_ch = 5'd7; last_ch = 5'd9; dwell = 8'd1; single = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            for (int k = 0; k < 3; k++) begin
                step();
                chk("t1_drive", 5'(ch), 1'b1, 1'b1, 1'b0);
            end
            step();
            if (ch < 2) chk("t1_setup", 5'(ch + 1), 1'b0, 1'b1, 1'b0);
            else        chk("t1_done", 5'd2, 1'b0, 1'b0, 1'b1);
        end
        step();
        chk("t1_idle", 5'd2, 1'b0, 1'b0, 1'b0);

        // Wrap 30..1, dwell 1
        first_ch = 5'd30; last_ch = 5'd1; dwell = 8'd1; single = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t2_setup30", 5'd30, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_drive", 5'(seq2[i]), 1'b1, 1'b1, 1'b0);
            step();
            if (i < 3) chk("t2_setup", 5'(seq2[i + 1]), 1'b0, 1'b1, 1'b0);
            else       chk("t2_done", 5'd1, 1'b0, 1'b0, 1'b1);
        end

        // Dwell 0 on a single channel
        first_ch = 5'd5; last_ch = 5'd5; dwell = 8'd0; single = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_setup", 5'd5, 1'b0, 1'b1, 1'b0);
        step();
        chk("t3_drive", 5'd5, 1'b1, 1'b1, 1'b0);
        step();
        chk("t3_done", 5'd5, 1'b0, 1'b0, 1'b1);
        step();
        chk("t3_idle", 5'd5, 1'b0, 1'b0, 1'b0);

        // Repeating 3..4, dwell 2, stopped during the second pass
        first_ch = 5'd3; last_ch = 5'd4; dwell = 8'd2; single = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        chk("t4_setup3", 5'd3, 1'b0, 1'b1, 1'b0);
        step(); chk("t4_drive3a", 5'd3, 1'b1, 1'b1, 1'b0);
        step(); chk("t4_drive3b", 5'd3, 1'b1, 1'b1, 1'b0);
        step(); chk("t4_setup4", 5'd4, 1'b0, 1'b1, 1'b0);
        step(); chk("t4_drive4a", 5'd4, 1'b1, 1'b1, 1'b0);
        step(); chk("t4_drive4b", 5'd4, 1'b1, 1'b1, 1'b0);
        step(); chk("t4_rewrap", 5'd3, 1'b0, 1'b1, 1'b0);
        step(); chk("t4_pass2_drive", 5'd3, 1'b1, 1'b1, 1'b0);
        stop = 1'b1;
        step(); chk("t4_stopped", 5'd3, 1'b0, 1'b0, 1'b0);
        stop = 1'b0;
        step(); chk("t4_no_done", 5'd3, 1'b0, 1'b0, 1'b0);
        first_ch = 5'd8; last_ch = 5'd8; dwell = 8'd1; single = 1'b1; start = 1'b1;
        step(); chk("t4_restart", 5'd8, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk("t4_re_drive", 5'd8, 1'b1, 1'b1, 1'b0);
        step(); chk("t4_re_done", 5'd8, 1'b0, 1'b0, 1'b1);

        // Start and stop together: stop wins
        first_ch = 5'd20; start = 1'b1; stop = 1'b1;
        step(); chk("t5_start_stop", 5'd8, 1'b0, 1'b0, 1'b0);
        start = 1'b0; stop = 1'b0;

        // Reset mid-DRIVE
        first_ch = 5'd10; last_ch = 5'd12; dwell = 8'd4; single = 1'b1; start = 1'b1;
        step(); chk("t5_setup10", 5'd10, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk("t5_drive10", 5'd10, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_async_reset", 5'd0, 1'b0, 1'b0, 1'b0);
        step(); chk("t5_in_reset", 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step(); chk("t5_post_reset", 5'd0, 1'b0, 1'b0, 1'b0);
        step(); chk("t5_no_resume", 5'd0, 1'b0, 1'b0, 1'b0);
        first_ch = 5'd1; last_ch = 5'd1; dwell = 8'd1; single = 1'b1; start = 1'b1;
        step(); chk("t5_restart", 5'd1, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk("t5_re_drive", 5'd1, 1'b1, 1'b1, 1'b0);
        step(); chk("t5_re_done", 5'd1, 1'b0, 1'b0, 1'b1);

`ifdef CH_MASK_EN
        // Mask 0x5 over 0..3: only channels 0 and 2 enabled
        ch_mask = 32'h0000_0005;
        first_ch = 5'd0; last_ch = 5'd3; dwell = 8'd1; single = 1'b1; start = 1'b1;
        step(); chk("t6_setup0", 5'd0, 1'b0, 1'b1, 1'b0);
        start = 1'b0;
        step(); chk("t6_drive0", 5'd0, 1'b1, 1'b1, 1'b0);
        step(); chk("t6_setup1", 5'd1, 1'b0, 1'b1, 1'b0);
        step(); chk("t6_setup2", 5'd2, 1'b0, 1'b1, 1'b0);
        step(); chk("t6_drive2", 5'd2, 1'b1, 1'b1, 1'b0);
        step(); chk("t6_setup3", 5'd3, 1'b0, 1'b1, 1'b0);
        step(); chk("t6_done", 5'd3, 1'b0, 1'b0, 1'b1);
        ch_mask = 32'hFFFF_FFFF;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
